// File: rtl/relu_backward.sv
// ReLU backward pass: stores forward masks (z > 0) in a FIFO and gates upstream gradients with them.
// Optional leaky variant: define RELU_BACKWARD_LEAKY_EN to pass g >>> LEAK_SHIFT on masked-off lanes.
module relu_backward #(
  parameter int INPUT_WIDTH = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int MASK_DEPTH  = 8,
  parameter int LEAK_SHIFT  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         z_valid,
  output logic                         z_ready,
  input  logic signed [DATA_WIDTH-1:0] z_in [INPUT_WIDTH],
  input  logic                         g_valid,
  output logic                         g_ready,
  input  logic signed [DATA_WIDTH-1:0] g_in [INPUT_WIDTH],
  output logic                         gout_valid,
  input  logic                         gout_ready,
  output logic signed [DATA_WIDTH-1:0] gout [INPUT_WIDTH],
  output logic [$clog2(MASK_DEPTH):0]  mask_count,
  input  logic                         flush
);

  localparam int AW = $clog2(MASK_DEPTH);
  localparam int CW = AW + 1;

  if ((MASK_DEPTH < 2) || ((MASK_DEPTH & (MASK_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("MASK_DEPTH must be a power of two and at least 2");
  end
  if ((LEAK_SHIFT < 0) || (LEAK_SHIFT >= DATA_WIDTH)) begin : g_bad_leak_shift
    $error("LEAK_SHIFT must lie in [0, DATA_WIDTH)");
  end

  logic [INPUT_WIDTH-1:0]        mask_mem_q [MASK_DEPTH];
  logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                 count_q, count_d;
  logic                          gout_valid_q, gout_valid_d;
  logic signed [DATA_WIDTH-1:0]  gout_q [INPUT_WIDTH];
  logic signed [DATA_WIDTH-1:0]  gout_d [INPUT_WIDTH];
  logic signed [DATA_WIDTH-1:0]  gated [INPUT_WIDTH];
  logic [INPUT_WIDTH-1:0]        z_mask;
  logic [INPUT_WIDTH-1:0]        rd_mask;
  logic                          push;
  logic                          pop;

  assign z_ready    = (count_q != CW'(MASK_DEPTH));
  assign g_ready    = (count_q != '0) && (!gout_valid_q || gout_ready) && !flush;
  assign push       = z_valid && z_ready && !flush;
  assign pop        = g_valid && g_ready;
  assign rd_mask    = mask_mem_q[rd_ptr_q];
  assign mask_count = count_q;
  assign gout_valid = gout_valid_q;
  assign gout       = gout_q;

  for (genvar gi = 0; gi < INPUT_WIDTH; gi++) begin : g_lane
    // Strictly positive: zero and the most-negative value both fall on the sign/zero test.
    assign z_mask[gi] = !z_in[gi][DATA_WIDTH-1] && (z_in[gi] != '0);
`ifdef RELU_BACKWARD_LEAKY_EN
    assign gated[gi] = rd_mask[gi] ? g_in[gi] : (g_in[gi] >>> LEAK_SHIFT);
`else
    assign gated[gi] = rd_mask[gi] ? g_in[gi] : '0;
`endif
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    gout_valid_d = gout_valid_q;
    gout_d       = gout_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      gout_valid_d = 1'b0;
      for (int i = 0; i < INPUT_WIDTH; i++) gout_d[i] = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + AW'(1);
        gout_valid_d = 1'b1;
        gout_d       = gated;
      end else if (gout_ready) begin
        gout_valid_d = 1'b0;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      gout_valid_q <= 1'b0;
      for (int i = 0; i < INPUT_WIDTH; i++) gout_q[i] <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      gout_valid_q <= gout_valid_d;
      gout_q       <= gout_d;
    end
  end

  // Mask storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mask_mem_q[wr_ptr_q] <= z_mask;
  end

endmodule

// File: tb/tb_relu_backward.sv
// Scoreboard bench for relu_backward: stimulus pushes expected gout vectors, a monitor pops and compares.
module tb_relu_backward;
  localparam int IW = 3;
  localparam int DW = 16;
  localparam int MD = 8;
  localparam int LS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic z_valid = 1'b0;
  logic g_valid = 1'b0;
  logic gout_ready = 1'b1;
  logic flush = 1'b0;
  logic z_ready, g_ready, gout_valid;
  logic signed [DW-1:0] z_in [IW];
  logic signed [DW-1:0] g_in [IW];
  logic signed [DW-1:0] gout [IW];
  logic [$clog2(MD):0] mask_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ntx = 0;
  logic [3*DW-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  relu_backward #(
    .INPUT_WIDTH(IW), .DATA_WIDTH(DW), .MASK_DEPTH(MD), .LEAK_SHIFT(LS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .z_valid(z_valid), .z_ready(z_ready), .z_in(z_in),
    .g_valid(g_valid), .g_ready(g_ready), .g_in(g_in),
    .gout_valid(gout_valid), .gout_ready(gout_ready), .gout(gout),
    .mask_count(mask_count), .flush(flush)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int neg_lane(input int g);
`ifdef RELU_BACKWARD_LEAKY_EN
    return g >>> LS;
`else
    return 0;
`endif
  endfunction

  function automatic int lane(input bit m, input int g);
    return m ? g : neg_lane(g);
  endfunction

  function automatic logic [3*DW-1:0] pack3(input int a, input int b, input int c);
    return {DW'(c), DW'(b), DW'(a)};
  endfunction

  // Tasks start just after a rising edge and return just after the edge that completes the handshake.
  task automatic push_z(input int a, input int b, input int c);
    bit ok = 0;
    z_in[0] = DW'(a); z_in[1] = DW'(b); z_in[2] = DW'(c);
    z_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (z_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("push_z_timeout", 0, 1);
    @(posedge clk); #1;
    z_valid = 1'b0;
  endtask

  task automatic push_pat(input int k);
    push_z(k[0] ? 10 : -10, k[1] ? 11 : -11, k[2] ? 12 : -12);
  endtask

  task automatic send_g(input int g0, input int g1, input int g2,
                        input int e0, input int e1, input int e2);
    bit ok = 0;
    g_in[0] = DW'(g0); g_in[1] = DW'(g1); g_in[2] = DW'(g2);
    g_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (g_ready) begin ok = 1; exp_q.push_back(pack3(e0, e1, e2)); break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("send_g_timeout", 0, 1);
    @(posedge clk); #1;
    g_valid = 1'b0;
  endtask

  task automatic push_pop(input int zk, input int pk);
    bit ok = 0;
    z_in[0] = DW'(zk[0] ? 10 : -10); z_in[1] = DW'(zk[1] ? 11 : -11); z_in[2] = DW'(zk[2] ? 12 : -12);
    g_in[0] = 16'sd100; g_in[1] = -16'sd200; g_in[2] = 16'sd300;
    z_valid = 1'b1;
    g_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (z_ready && g_ready) begin
        ok = 1;
        exp_q.push_back(pack3(lane(pk[0], 100), lane(pk[1], -200), lane(pk[2], 300)));
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("push_pop_timeout", 0, 1);
    @(posedge clk); #1;
    z_valid = 1'b0;
    g_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    logic [3*DW-1:0] e;
    if (rst_n && gout_valid && gout_ready) begin
      if (exp_q.size() == 0) begin
        chk("gout_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        ntx++;
        $display("txn %0d: gout=[%0d,%0d,%0d] expected=[%0d,%0d,%0d]", ntx,
                 gout[0], gout[1], gout[2],
                 $signed(e[DW-1:0]), $signed(e[2*DW-1:DW]), $signed(e[3*DW-1:2*DW]));
        chk("gout_lane0", gout[0], $signed(e[DW-1:0]));
        chk("gout_lane1", gout[1], $signed(e[2*DW-1:DW]));
        chk("gout_lane2", gout[2], $signed(e[3*DW-1:2*DW]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    for (int i = 0; i < IW; i++) begin z_in[i] = '0; g_in[i] = '0; end

    // Reset state
    @(negedge clk);
    chk("rst_mask_count", mask_count, 0);
    chk("rst_z_ready", z_ready, 1);
    chk("rst_g_ready", g_ready, 0);
    chk("rst_gout_valid", gout_valid, 0);
    chk("rst_gout0", gout[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mask gating, latency 1
    push_z(15, -20, 30);
    send_g(7, 7, 7, 7, 0, 7);
    chk("lat_gout_valid", gout_valid, 1);
    chk("lat_count", mask_count, 0);

    // Empty: gradient must not be taken
    g_valid = 1'b1;
    @(negedge clk);
    chk("empty_g_ready", g_ready, 0);
    @(posedge clk); #1;
    g_valid = 1'b0;

    // Full, overflow attempt, then ordered drain
    for (int k = 0; k < 8; k++) push_pat(k);
    chk("full_count", mask_count, 8);
    chk("full_z_ready", z_ready, 0);
    z_valid = 1'b1;
    @(posedge clk); #1;
    z_valid = 1'b0;
    chk("full_no_push", mask_count, 8);
    for (int k = 0; k < 8; k++)
      send_g(100, -200, 300, lane(k[0], 100), lane(k[1], -200), lane(k[2], 300));
    chk("drain_count", mask_count, 0);

    // Backpressure hold then back-to-back flow
    for (int k = 0; k < 4; k++) push_z(1, -1, 1);
    gout_ready = 1'b0;
    send_g(5, 7, 8, 5, 0, 8);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", gout_valid, 1);
      chk("hold_lane0", gout[0], 5);
      chk("hold_lane1", gout[1], 0);
      chk("hold_lane2", gout[2], 8);
      chk("hold_g_ready", g_ready, 0);
      @(posedge clk); #1;
    end
    gout_ready = 1'b1;
    c0 = cyc;
    send_g(1, 2, 3, 1, 0, 3);
    send_g(-4, 5, 6, -4, 0, 6);
    send_g(9, 16, -9, 9, lane(0, 16), -9);
    chk("b2b_cycles", cyc - c0, 3);
    chk("b2b_count", mask_count, 0);

    // Simultaneous push/pop at count 4, with pointer wrap
    for (int k = 0; k < 4; k++) push_pat(k);
    push_pop(4, 0);
    chk("pushpop_count", mask_count, 4);
    for (int k = 5; k < 24; k++) push_pop(k % 8, (k - 4) % 8);
    chk("wrap_count", mask_count, 4);

    // Flush mid-stream with count 5 and a held output
    push_pat(1);
    push_pat(2);
    gout_ready = 1'b0;
    send_g(5, 7, 8, 0, 0, 0);
    chk("pre_flush_count", mask_count, 5);
    chk("pre_flush_valid", gout_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_g_ready", g_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    chk("flush_count", mask_count, 0);
    chk("flush_valid", gout_valid, 0);
    chk("flush_z_ready", z_ready, 1);
    gout_ready = 1'b1;
    push_z(15, -20, 30);
    send_g(7, 7, 7, 7, 0, 7);

    // Asynchronous reset mid-stream
    for (int k = 0; k < 6; k++) push_z(1, 1, 1);
    gout_ready = 1'b0;
    send_g(5, 7, 8, 0, 0, 0);
    chk("pre_rst_count", mask_count, 5);
    chk("pre_rst_gout0", gout[0], 5);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_mid_count", mask_count, 0);
    chk("rst_mid_valid", gout_valid, 0);
    chk("rst_mid_gout0", gout[0], 0);
    chk("rst_mid_z_ready", z_ready, 1);
    chk("rst_mid_g_ready", g_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    gout_ready = 1'b1;
    @(posedge clk); #1;

    // Edge values
    push_z(-32768, 0, 32767);
`ifdef RELU_BACKWARD_LEAKY_EN
    send_g(-64, 64, 64, -8, 8, 64);
`else
    send_g(-64, 64, 64, 0, 0, 64);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/relu_backward.md
RELU_BACKWARD -- requirements
Module: relu_backward

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 3: number of vector lanes.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: signed two's-complement lane width.
REQ-003 SHALL have parameter MASK_DEPTH, default 8: mask FIFO entries, power of two, >= 2.
REQ-004 SHALL have parameter LEAK_SHIFT, default 3: right-shift for the negative-side gradient (used only under REQ-030).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port z_valid, input, 1: forward pre-activation vector present.
REQ-008 SHALL have port z_ready, output, 1: a mask can be stored.
REQ-009 SHALL have port z_in, input, signed [DATA_WIDTH-1:0] x INPUT_WIDTH: forward pre-activations.
REQ-010 SHALL have port g_valid, input, 1: upstream gradient vector present.
REQ-011 SHALL have port g_ready, output, 1: gradient accepted this cycle.
REQ-012 SHALL have port g_in, input, signed [DATA_WIDTH-1:0] x INPUT_WIDTH: upstream gradient dL/da.
REQ-013 SHALL have port gout_valid, output, 1: gated gradient valid.
REQ-014 SHALL have port gout_ready, input, 1: downstream accepts gout.
REQ-015 SHALL have port gout, output, signed [DATA_WIDTH-1:0] x INPUT_WIDTH: gradient dL/dz.
REQ-016 SHALL have port mask_count, output, $clog2(MASK_DEPTH)+1: stored mask count.
REQ-017 SHALL have port flush, input, 1: synchronous clear of FIFO and output stage.

Function
REQ-018 SHALL push an INPUT_WIDTH-bit mask, bit i = (z_in[i] > 0), into the FIFO when z_valid && z_ready.
REQ-019 SHALL drive z_ready = (mask_count != MASK_DEPTH); pushing while full is not possible.
REQ-020 SHALL drive g_ready = (mask_count != 0) && (!gout_valid || gout_ready) && !flush.
REQ-021 SHALL, on g_valid && g_ready, pop the oldest mask and register gout[i] = mask[i] ? g_in[i] : 0, setting gout_valid on the next cycle (latency 1).
REQ-022 SHALL hold gout and gout_valid stable while gout_valid && !gout_ready.
REQ-023 SHALL clear gout_valid after a transfer unless a new gradient is accepted in the same cycle; a new acceptance gives back-to-back throughput of one vector per cycle.
REQ-024 SHALL, on a simultaneous push and pop, leave mask_count unchanged and keep FIFO order; a push at count 0 is not poppable until the next cycle.
REQ-025 SHALL wrap read and write pointers modulo MASK_DEPTH.
REQ-026 SHALL give flush priority over push and pop: next cycle mask_count=0, gout_valid=0, pointers 0, and z_ready=1.
REQ-027 SHALL treat z_in = 0 and z_in = -2^(DATA_WIDTH-1) as mask bit 0.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force mask_count=0, pointers=0, gout_valid=0, gout=0, z_ready=1, g_ready=0, and discard any in-flight vector.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst_n deasserts, with no pending data.

Configuration
REQ-030 SHALL support macro RELU_BACKWARD_LEAKY_EN: when defined, lanes with mask bit 0 output g_in[i] >>> LEAK_SHIFT (arithmetic shift, sign-preserving); when undefined, they output 0 and LEAK_SHIFT is unused.

Verification
REQ-031 SHALL cover mask gating: push z=[15,-20,30], then g=[7,7,7] -> gout=[7,0,7] one cycle after acceptance.
REQ-032 SHALL cover full/empty: push 8 masks -> z_ready=0, mask_count=8; g_ready=0 while mask_count=0; pop 8 gradients -> masks return in push order.
REQ-033 SHALL cover backpressure: hold gout_ready=0 for 3 cycles with gout=[5,0,8] -> gout stable, g_ready=0; release -> one transfer, then back-to-back flow.
REQ-034 SHALL cover simultaneous push and pop at mask_count=4 -> mask_count remains 4; pointer wrap after 20 pushes/pops shows no order error.
REQ-035 SHALL cover reset and flush mid-stream: assert rst_n=0 (or flush=1) with mask_count=5 and gout_valid=1 -> mask_count=0, gout_valid=0 immediately (reset) or next cycle (flush).
REQ-036 SHALL cover edge values with RELU_BACKWARD_LEAKY_EN defined: z=[-32768,0,32767], g=[-64,64,64] -> gout=[-8,8,64]; without the macro -> gout=[0,0,64].
